// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core accesses into one or two word-bus
// accesses, splitting misaligned ones and extending load results.
module load_store_unit #(
  parameter int unsigned addrWidth = 32,
  parameter int unsigned dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWe,
  input  logic [2:0]           reqMemOp,
  input  logic [addrWidth-1:0] reqAddr,
  input  logic [dataWidth-1:0] reqWdata,
  output logic                 rspValid,
  output logic [dataWidth-1:0] rspRdata,
  output logic                 rspErr,
  output logic                 memReq,
  input  logic                 memAck,
  output logic                 memWe,
  output logic [addrWidth-1:0] memAddr,
  output logic [dataWidth-1:0] memWdata,
  output logic [3:0]           memWmask,
  input  logic [dataWidth-1:0] memRdata
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e stateQ, stateD;

  logic                 weQ, errQ, splitQ;
  logic [2:0]           opQ;
  logic [addrWidth-1:0] addrQ;
  logic [dataWidth-1:0] wdataQ, loQ, hiQ;

  logic                   reqIllegal, reqSplit;
  logic [3:0]             sizeMask;
  logic [7:0]             maskShift;
  logic [2*dataWidth-1:0] wdataShift, loadShift;
  logic [addrWidth-1:0]   word0Addr, word1Addr;
  logic [dataWidth-1:0]   loadResult;

  // Stores with BU/HU are rejected along with the undefined encodings.
  assign reqIllegal = (reqMemOp == 3'd3) || (reqMemOp[2:1] == 2'b11) || (reqWe && reqMemOp[2]);

  always_comb begin
    reqSplit = 1'b0;
    unique case (reqMemOp[1:0])
      2'd1:    reqSplit = (reqAddr[1:0] == 2'd3);
      2'd2:    reqSplit = (reqAddr[1:0] != 2'd0);
      default: reqSplit = 1'b0;
    endcase
  end

  always_comb begin
    sizeMask = 4'b0001;
    unique case (opQ[1:0])
      2'd1:    sizeMask = 4'b0011;
      2'd2:    sizeMask = 4'b1111;
      default: sizeMask = 4'b0001;
    endcase
  end

  // Low half of each shift feeds the first access, high half the second.
  assign maskShift  = {4'b0000, sizeMask} << addrQ[1:0];
  assign wdataShift = {{dataWidth{1'b0}}, wdataQ} << {addrQ[1:0], 3'b000};
  assign loadShift  = {hiQ, loQ} >> {addrQ[1:0], 3'b000};
  assign word0Addr  = {addrQ[addrWidth-1:2], 2'b00};
  assign word1Addr  = word0Addr + {{(addrWidth-3){1'b0}}, 3'b100};

  always_comb begin
    loadResult = loadShift[dataWidth-1:0];
    unique case (opQ)
      3'd0:    loadResult = {{24{loadShift[7]}}, loadShift[7:0]};
      3'd1:    loadResult = {{16{loadShift[15]}}, loadShift[15:0]};
      3'd4:    loadResult = {24'd0, loadShift[7:0]};
      3'd5:    loadResult = {16'd0, loadShift[15:0]};
      default: loadResult = loadShift[dataWidth-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (reqValid) stateD = reqIllegal ? StResp : StAcc0;
      StAcc0: if (memAck) stateD = splitQ ? StAcc1 : StResp;
      StAcc1: if (memAck) stateD = StResp;
      StResp: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weQ    <= 1'b0;
      errQ   <= 1'b0;
      splitQ <= 1'b0;
      opQ    <= 3'd0;
      addrQ  <= '0;
      wdataQ <= '0;
      loQ    <= '0;
      hiQ    <= '0;
    end else begin
      if (stateQ == StIdle && reqValid) begin
        weQ    <= reqWe;
        errQ   <= reqIllegal;
        splitQ <= reqSplit;
        opQ    <= reqMemOp;
        addrQ  <= reqAddr;
        wdataQ <= reqWdata;
        loQ    <= '0;
        hiQ    <= '0;
      end
      if (stateQ == StAcc0 && memAck) loQ <= memRdata;
      if (stateQ == StAcc1 && memAck) hiQ <= memRdata;
    end
  end

  always_comb begin
    reqReady = 1'b0;
    memReq   = 1'b0;
    memWe    = 1'b0;
    memAddr  = word0Addr;
    memWmask = weQ ? maskShift[3:0] : 4'b1111;
    memWdata = wdataShift[dataWidth-1:0];
    rspValid = 1'b0;
    rspErr   = 1'b0;
    rspRdata = '0;
    unique case (stateQ)
      StIdle: reqReady = 1'b1;
      StAcc0: begin
        memReq = 1'b1;
        memWe  = weQ;
      end
      StAcc1: begin
        memReq   = 1'b1;
        memWe    = weQ;
        memAddr  = word1Addr;
        memWmask = weQ ? maskShift[7:4] : 4'b1111;
        memWdata = wdataShift[2*dataWidth-1:dataWidth];
      end
      StResp: begin
        rspValid = 1'b1;
        rspErr   = errQ;
        rspRdata = (errQ || weQ) ? '0 : loadResult;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs change and outputs are checked on
// the falling edge, so each step spans exactly one rising edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqWe;
  logic [2:0]  reqMemOp;
  logic [31:0] reqAddr, reqWdata;
  logic        rspValid, rspErr;
  logic [31:0] rspRdata;
  logic        memReq, memAck, memWe;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWe(reqWe), .reqMemOp(reqMemOp),
    .reqAddr(reqAddr), .reqWdata(reqWdata),
    .rspValid(rspValid), .rspRdata(rspRdata), .rspErr(rspErr),
    .memReq(memReq), .memAck(memAck), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memWmask(memWmask), .memRdata(memRdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents a request for one cycle; on return the request has been accepted.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    chk("reqReady_before_issue", {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1;
    reqWe    = we;
    reqMemOp = op;
    reqAddr  = addr;
    reqWdata = wdata;
    step();
    reqValid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata);
    memAck   = 1'b1;
    memRdata = rdata;
    step();
    memAck   = 1'b0;
    memRdata = 32'hDEAD_BEEF;
  endtask

  task automatic chk_acc(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] mask);
    chk({tag, "_memReq"}, {31'd0, memReq}, 32'd1);
    chk({tag, "_memWe"}, {31'd0, memWe}, {31'd0, we});
    chk({tag, "_memAddr"}, memAddr, addr);
    chk({tag, "_memWmask"}, {28'd0, memWmask}, {28'd0, mask});
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] rdata, input logic err);
    chk({tag, "_rspValid"}, {31'd0, rspValid}, 32'd1);
    chk({tag, "_rspErr"}, {31'd0, rspErr}, {31'd0, err});
    chk({tag, "_rspRdata"}, rspRdata, rdata);
    chk({tag, "_memReq_resp"}, {31'd0, memReq}, 32'd0);
    step();
    chk({tag, "_rspValid_drop"}, {31'd0, rspValid}, 32'd0);
    chk({tag, "_rspErr_drop"}, {31'd0, rspErr}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqMemOp = 3'd0;
    reqAddr = '0; reqWdata = '0; memAck = 1'b0; memRdata = 32'hDEAD_BEEF;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_reqReady", {31'd0, reqReady}, 32'd1);
    chk("reset_memReq", {31'd0, memReq}, 32'd0);
    chk("reset_rspValid", {31'd0, rspValid}, 32'd0);
    chk("reset_rspErr", {31'd0, rspErr}, 32'd0);
    chk("reset_rspRdata", rspRdata, 32'd0);

    // LW 0x100, zero-wait ack
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    chk("lw_reqReady_busy", {31'd0, reqReady}, 32'd0);
    chk_acc("lw_acc0", 1'b0, 32'h0000_0100, 4'b1111);
    ack(32'h8899_AABB);
    chk_rsp("lw", 32'h8899_AABB, 1'b0);
    chk("lw_ready_after", {31'd0, reqReady}, 32'd1);

    // LB / LBU at 0x103, top byte 0x80
    issue(1'b0, 3'd0, 32'h0000_0103, 32'd0);
    chk_acc("lb_acc0", 1'b0, 32'h0000_0100, 4'b1111);
    ack(32'h8012_3456);
    chk_rsp("lb", 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'd4, 32'h0000_0103, 32'd0);
    ack(32'h8012_3456);
    chk_rsp("lbu", 32'h0000_0080, 1'b0);

    // LH at 0x102 fits in one word
    issue(1'b0, 3'd1, 32'h0000_0102, 32'd0);
    ack(32'h8001_5555);
    chk_rsp("lh_off2", 32'hFFFF_8001, 1'b0);

    // SB 0xA5 at 0x101
    issue(1'b1, 3'd0, 32'h0000_0101, 32'h0000_00A5);
    chk_acc("sb_acc0", 1'b1, 32'h0000_0100, 4'b0010);
    chk("sb_wdata", memWdata, 32'h0000_A500);
    ack(32'd0);
    chk_rsp("sb", 32'd0, 1'b0);

    // SW 0x11223344 at 0x102, one wait state in the first access
    issue(1'b1, 3'd2, 32'h0000_0102, 32'h1122_3344);
    chk_acc("sw_acc0", 1'b1, 32'h0000_0100, 4'b1100);
    chk("sw_acc0_wdata", memWdata, 32'h3344_0000);
    step();
    chk_acc("sw_acc0_hold", 1'b1, 32'h0000_0100, 4'b1100);
    chk("sw_acc0_hold_wdata", memWdata, 32'h3344_0000);
    ack(32'd0);
    chk_acc("sw_acc1", 1'b1, 32'h0000_0104, 4'b0011);
    chk("sw_acc1_wdata", memWdata, 32'h0000_1122);
    ack(32'd0);
    chk_rsp("sw", 32'd0, 1'b0);

    // LH at 0xFFFFFFFF wraps to word 0
    issue(1'b0, 3'd1, 32'hFFFF_FFFF, 32'd0);
    chk_acc("lh_wrap_acc0", 1'b0, 32'hFFFF_FFFC, 4'b1111);
    ack(32'hAB00_0000);
    chk_acc("lh_wrap_acc1", 1'b0, 32'h0000_0000, 4'b1111);
    ack(32'h0000_00CD);
    chk_rsp("lh_wrap", 32'hFFFF_CDAB, 1'b0);

    // Illegal op 3 and store-BU: no bus access, error pulse
    issue(1'b0, 3'd3, 32'h0000_0200, 32'd0);
    chk("op3_no_memReq", {31'd0, memReq}, 32'd0);
    chk_rsp("op3", 32'd0, 1'b1);
    issue(1'b1, 3'd4, 32'h0000_0200, 32'hFFFF_FFFF);
    chk("sbu_no_memReq", {31'd0, memReq}, 32'd0);
    chk_rsp("sbu", 32'd0, 1'b1);

    // Ack while idle is ignored
    memAck = 1'b1; memRdata = 32'h1234_5678;
    step();
    memAck = 1'b0;
    chk("idle_ack_memReq", {31'd0, memReq}, 32'd0);
    chk("idle_ack_rspValid", {31'd0, rspValid}, 32'd0);

    // Reset mid-access, then a late ack
    issue(1'b0, 3'd2, 32'h0000_0300, 32'd0);
    chk("rst_mid_memReq", {31'd0, memReq}, 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold_memReq", {31'd0, memReq}, 32'd0);
      chk("rst_hold_rspValid", {31'd0, rspValid}, 32'd0);
    end
    rst = 1'b0;
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    chk("rst_rel_reqReady", {31'd0, reqReady}, 32'd1);
    chk("rst_rel_rspValid", {31'd0, rspValid}, 32'd0);
    chk("rst_rel_memReq", {31'd0, memReq}, 32'd0);

    // Unit is still usable after the abandoned access
    issue(1'b0, 3'd5, 32'h0000_0402, 32'd0);
    ack(32'hF00D_1111);
    chk_rsp("lhu_after_rst", 32'h0000_F00D, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
